// File: rtl/multicycle_control_unit.sv
// Registered opcode decoder with a RUN/MEM/WB stall sequencer for data-memory ops.
// Memory ops hold the PC while BUSYWAIT is high and abort after MEM_TIMEOUT busy cycles.
module multicycle_control_unit #(
  parameter int unsigned OPCODE_W    = 8,
  parameter int unsigned ALUOP_W     = 3,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [OPCODE_W-1:0] OPCODE,
  input  logic                INSTR_VALID,
  input  logic                BUSYWAIT,
  output logic                IMM,
  output logic                SIGN,
  output logic                WRITEENABLE,
  output logic                WRITESRC,
  output logic                J,
  output logic                BEQ,
  output logic                BNE,
  output logic [ALUOP_W-1:0]  ALUOP,
  output logic                MEMREAD,
  output logic                MEMWRITE,
  output logic                PC_STALL,
  output logic                ILLEGAL,
  output logic                MEM_ERR
);

  localparam logic [OPCODE_W-1:0] OP_LOADI = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_MOV   = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_SUB   = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_AND   = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_OR    = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_MULT  = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_LWD   = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] OP_LWI   = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] OP_SWD   = OPCODE_W'(12);
  localparam logic [OPCODE_W-1:0] OP_SWI   = OPCODE_W'(13);

  localparam logic [ALUOP_W-1:0] ALU_FWD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_MUL = ALUOP_W'(4);

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_MEM = 2'd1,
    ST_WB  = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;

  logic               d_imm;
  logic               d_sign;
  logic               d_we;
  logic               d_j;
  logic               d_beq;
  logic               d_bne;
  logic [ALUOP_W-1:0] d_aluop;
  logic               d_rd;
  logic               d_wr;
  logic               d_legal;

  assign cnt_next = cnt + CNT_W'(1);

  // Opcode map decode; every field defaults to 0 so unlisted signals stay low.
  always_comb begin
    d_imm   = 1'b0;
    d_sign  = 1'b0;
    d_we    = 1'b0;
    d_j     = 1'b0;
    d_beq   = 1'b0;
    d_bne   = 1'b0;
    d_aluop = ALU_FWD;
    d_rd    = 1'b0;
    d_wr    = 1'b0;
    d_legal = 1'b1;
    case (OPCODE)
      OP_LOADI: begin d_imm = 1'b1; d_we = 1'b1; end
      OP_MOV:   d_we = 1'b1;
      OP_ADD:   begin d_we = 1'b1; d_aluop = ALU_ADD; end
      OP_SUB:   begin d_we = 1'b1; d_sign = 1'b1; d_aluop = ALU_ADD; end
      OP_AND:   begin d_we = 1'b1; d_aluop = ALU_AND; end
      OP_OR:    begin d_we = 1'b1; d_aluop = ALU_OR; end
      OP_J:     d_j = 1'b1;
      OP_BEQ:   begin d_sign = 1'b1; d_aluop = ALU_ADD; d_beq = 1'b1; end
      OP_BNE:   begin d_sign = 1'b1; d_aluop = ALU_ADD; d_bne = 1'b1; end
      OP_MULT:  begin d_we = 1'b1; d_aluop = ALU_MUL; end
      OP_LWD:   d_rd = 1'b1;
      OP_LWI:   begin d_imm = 1'b1; d_rd = 1'b1; end
      OP_SWD:   d_wr = 1'b1;
      OP_SWI:   begin d_imm = 1'b1; d_wr = 1'b1; end
      default:  d_legal = 1'b0;
    endcase
  end

  // Sequencer: outputs default to 0 each edge and are only held while MEM waits.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ST_RUN;
      cnt         <= '0;
      IMM         <= 1'b0;
      SIGN        <= 1'b0;
      WRITEENABLE <= 1'b0;
      WRITESRC    <= 1'b0;
      J           <= 1'b0;
      BEQ         <= 1'b0;
      BNE         <= 1'b0;
      ALUOP       <= '0;
      MEMREAD     <= 1'b0;
      MEMWRITE    <= 1'b0;
      PC_STALL    <= 1'b0;
      ILLEGAL     <= 1'b0;
      MEM_ERR     <= 1'b0;
    end else begin
      IMM         <= 1'b0;
      SIGN        <= 1'b0;
      WRITEENABLE <= 1'b0;
      WRITESRC    <= 1'b0;
      J           <= 1'b0;
      BEQ         <= 1'b0;
      BNE         <= 1'b0;
      ALUOP       <= '0;
      MEMREAD     <= 1'b0;
      MEMWRITE    <= 1'b0;
      PC_STALL    <= 1'b0;
      ILLEGAL     <= 1'b0;
      MEM_ERR     <= 1'b0;
      case (state)
        ST_RUN: begin
          if (INSTR_VALID) begin
            if (!d_legal) begin
              ILLEGAL <= 1'b1;
            end else begin
              IMM         <= d_imm;
              SIGN        <= d_sign;
              WRITEENABLE <= d_we;
              J           <= d_j;
              BEQ         <= d_beq;
              BNE         <= d_bne;
              ALUOP       <= d_aluop;
              MEMREAD     <= d_rd;
              MEMWRITE    <= d_wr;
              PC_STALL    <= d_rd | d_wr;
              if (d_rd || d_wr) begin
                state <= ST_MEM;
                cnt   <= '0;
              end
            end
          end
        end
        ST_MEM: begin
          if (!BUSYWAIT) begin
            // MEMREAD still high here marks the op as a load.
            if (MEMREAD) begin
              state       <= ST_WB;
              WRITEENABLE <= 1'b1;
              WRITESRC    <= 1'b1;
              PC_STALL    <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end else if (cnt_next == TIMEOUT) begin
            cnt     <= cnt_next;
            MEM_ERR <= 1'b1;
            state   <= ST_RUN;
          end else begin
            cnt      <= cnt_next;
            IMM      <= IMM;
            ALUOP    <= ALUOP;
            MEMREAD  <= MEMREAD;
            MEMWRITE <= MEMWRITE;
            PC_STALL <= 1'b1;
          end
        end
        ST_WB: begin
          state <= ST_RUN;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: default instance plus a MEM_TIMEOUT=5 instance
// sharing the same inputs; outputs are packed as {IMM,SIGN,WE,WRITESRC,J,BEQ,BNE,ALUOP,RD,WR,STALL,ILL,ERR}.
module tb_multicycle_control_unit;

  logic       CLK;
  logic       RESET;
  logic [7:0] OPCODE;
  logic       INSTR_VALID;
  logic       BUSYWAIT;

  logic       a_imm, a_sign, a_we, a_ws, a_j, a_beq, a_bne, a_rd, a_wr, a_st, a_ill, a_err;
  logic [2:0] a_alu;
  logic       b_imm, b_sign, b_we, b_ws, b_j, b_beq, b_bne, b_rd, b_wr, b_st, b_ill, b_err;
  logic [2:0] b_alu;

  logic [14:0] outs_a;
  logic [14:0] outs_b;
  logic [14:0] exp_v;

  int checks = 0;
  int errors = 0;

  assign outs_a = {a_imm, a_sign, a_we, a_ws, a_j, a_beq, a_bne, a_alu, a_rd, a_wr, a_st, a_ill, a_err};
  assign outs_b = {b_imm, b_sign, b_we, b_ws, b_j, b_beq, b_bne, b_alu, b_rd, b_wr, b_st, b_ill, b_err};

  multicycle_control_unit dut (
    .CLK(CLK), .RESET(RESET), .OPCODE(OPCODE), .INSTR_VALID(INSTR_VALID), .BUSYWAIT(BUSYWAIT),
    .IMM(a_imm), .SIGN(a_sign), .WRITEENABLE(a_we), .WRITESRC(a_ws), .J(a_j), .BEQ(a_beq),
    .BNE(a_bne), .ALUOP(a_alu), .MEMREAD(a_rd), .MEMWRITE(a_wr), .PC_STALL(a_st),
    .ILLEGAL(a_ill), .MEM_ERR(a_err)
  );

  multicycle_control_unit #(.MEM_TIMEOUT(5)) dut5 (
    .CLK(CLK), .RESET(RESET), .OPCODE(OPCODE), .INSTR_VALID(INSTR_VALID), .BUSYWAIT(BUSYWAIT),
    .IMM(b_imm), .SIGN(b_sign), .WRITEENABLE(b_we), .WRITESRC(b_ws), .J(b_j), .BEQ(b_beq),
    .BNE(b_bne), .ALUOP(b_alu), .MEMREAD(b_rd), .MEMWRITE(b_wr), .PC_STALL(b_st),
    .ILLEGAL(b_ill), .MEM_ERR(b_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Build an expected output vector from individual fields.
  function automatic logic [14:0] mk(input logic imm, input logic sign, input logic we,
                                     input logic ws, input logic j, input logic beq,
                                     input logic bne, input logic [2:0] alu, input logic rd,
                                     input logic wr, input logic st, input logic ill,
                                     input logic err);
    return {imm, sign, we, ws, j, beq, bne, alu, rd, wr, st, ill, err};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; OPCODE = 8'd2; INSTR_VALID = 1'b1; BUSYWAIT = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (outs_a !== 15'd0 || outs_b !== 15'd0) begin
        errors++;
        $display("FAIL reset_%0d got %b/%b want %b", i, outs_a, outs_b, 15'd0);
      end
    end
    RESET = 1'b0;
    step();
    exp_v = mk(0,0,1,0,0,0,0,3'b001,0,0,0,0,0);
    checks++;
    if (outs_a !== exp_v) begin
      errors++;
      $display("FAIL add_after_reset got %b want %b", outs_a, exp_v);
    end
    INSTR_VALID = 1'b0;
    step();
    checks++;
    if (outs_a !== 15'd0) begin
      errors++;
      $display("FAIL bubble got %b want %b", outs_a, 15'd0);
    end
  endtask

  task automatic test_alu_seq();
    logic [7:0]  ops [6];
    logic [14:0] exps[6];
    ops[0] = 8'd0; exps[0] = mk(1,0,1,0,0,0,0,3'b000,0,0,0,0,0);
    ops[1] = 8'd3; exps[1] = mk(0,1,1,0,0,0,0,3'b001,0,0,0,0,0);
    ops[2] = 8'd7; exps[2] = mk(0,1,0,0,0,1,0,3'b001,0,0,0,0,0);
    ops[3] = 8'd8; exps[3] = mk(0,1,0,0,0,0,1,3'b001,0,0,0,0,0);
    ops[4] = 8'd6; exps[4] = mk(0,0,0,0,1,0,0,3'b000,0,0,0,0,0);
    ops[5] = 8'd9; exps[5] = mk(0,0,1,0,0,0,0,3'b100,0,0,0,0,0);
    INSTR_VALID = 1'b1;
    for (int i = 0; i < 6; i++) begin
      OPCODE = ops[i];
      step();
      checks++;
      if (outs_a !== exps[i]) begin
        errors++;
        $display("FAIL alu_op%0d got %b want %b", ops[i], outs_a, exps[i]);
      end
    end
    OPCODE = 8'd4;
    step();
    exp_v = mk(0,0,1,0,0,0,0,3'b010,0,0,0,0,0);
    checks++;
    if (outs_a !== exp_v) begin
      errors++;
      $display("FAIL and got %b want %b", outs_a, exp_v);
    end
    INSTR_VALID = 1'b0;
    step();
  endtask

  task automatic test_load_busy();
    OPCODE = 8'd10; INSTR_VALID = 1'b1; BUSYWAIT = 1'b1;
    step();
    exp_v = mk(0,0,0,0,0,0,0,3'b000,1,0,1,0,0);
    checks++;
    if (outs_a !== exp_v) begin
      errors++;
      $display("FAIL lwd_issue got %b want %b", outs_a, exp_v);
    end
    // A new instruction presented during MEM must be ignored.
    OPCODE = 8'd2;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (outs_a !== exp_v || outs_b !== exp_v) begin
        errors++;
        $display("FAIL lwd_wait%0d got %b/%b want %b", i, outs_a, outs_b, exp_v);
      end
    end
    BUSYWAIT = 1'b0; INSTR_VALID = 1'b0;
    step();
    exp_v = mk(0,0,1,1,0,0,0,3'b000,0,0,1,0,0);
    checks++;
    if (outs_a !== exp_v || outs_b !== exp_v) begin
      errors++;
      $display("FAIL lwd_wb got %b/%b want %b", outs_a, outs_b, exp_v);
    end
    step();
    checks++;
    if (outs_a !== 15'd0) begin
      errors++;
      $display("FAIL lwd_done got %b want %b", outs_a, 15'd0);
    end
  endtask

  task automatic test_store_fast();
    OPCODE = 8'd13; INSTR_VALID = 1'b1; BUSYWAIT = 1'b0;
    step();
    exp_v = mk(1,0,0,0,0,0,0,3'b000,0,1,1,0,0);
    checks++;
    if (outs_a !== exp_v) begin
      errors++;
      $display("FAIL swi_issue got %b want %b", outs_a, exp_v);
    end
    INSTR_VALID = 1'b0;
    step();
    checks++;
    if (outs_a !== 15'd0) begin
      errors++;
      $display("FAIL swi_done got %b want %b", outs_a, 15'd0);
    end
  endtask

  task automatic test_timeout();
    OPCODE = 8'd11; INSTR_VALID = 1'b1; BUSYWAIT = 1'b1;
    step();
    exp_v = mk(1,0,0,0,0,0,0,3'b000,1,0,1,0,0);
    INSTR_VALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (outs_b !== exp_v) begin
        errors++;
        $display("FAIL lwi_wait%0d got %b want %b", i, outs_b, exp_v);
      end
      step();
    end
    exp_v = mk(0,0,0,0,0,0,0,3'b000,0,0,0,0,1);
    checks++;
    if (outs_b !== exp_v) begin
      errors++;
      $display("FAIL mem_err got %b want %b", outs_b, exp_v);
    end
    step();
    checks++;
    if (outs_b !== 15'd0) begin
      errors++;
      $display("FAIL mem_err_pulse got %b want %b", outs_b, 15'd0);
    end
    // Default instance has a far larger timeout and is still waiting.
    exp_v = mk(1,0,0,0,0,0,0,3'b000,1,0,1,0,0);
    checks++;
    if (outs_a !== exp_v) begin
      errors++;
      $display("FAIL no_timeout_default got %b want %b", outs_a, exp_v);
    end
    BUSYWAIT = 1'b0;
    step();
    exp_v = mk(0,0,1,1,0,0,0,3'b000,0,0,1,0,0);
    checks++;
    if (outs_a !== exp_v || outs_b !== 15'd0) begin
      errors++;
      $display("FAIL after_timeout got %b/%b want %b/%b", outs_a, outs_b, exp_v, 15'd0);
    end
    step();
  endtask

  task automatic test_illegal();
    OPCODE = 8'hFF; INSTR_VALID = 1'b1;
    step();
    exp_v = mk(0,0,0,0,0,0,0,3'b000,0,0,0,1,0);
    checks++;
    if (outs_a !== exp_v) begin
      errors++;
      $display("FAIL illegal_ff got %b want %b", outs_a, exp_v);
    end
    OPCODE = 8'd14;
    step();
    checks++;
    if (outs_a !== exp_v) begin
      errors++;
      $display("FAIL illegal_14 got %b want %b", outs_a, exp_v);
    end
    INSTR_VALID = 1'b0;
    step();
    checks++;
    if (outs_a !== 15'd0) begin
      errors++;
      $display("FAIL illegal_pulse got %b want %b", outs_a, 15'd0);
    end
  endtask

  task automatic test_reset_mid_mem();
    OPCODE = 8'd10; INSTR_VALID = 1'b1; BUSYWAIT = 1'b1;
    step();
    INSTR_VALID = 1'b0;
    step();
    exp_v = mk(0,0,0,0,0,0,0,3'b000,1,0,1,0,0);
    checks++;
    if (outs_a !== exp_v) begin
      errors++;
      $display("FAIL mid_mem got %b want %b", outs_a, exp_v);
    end
    RESET = 1'b1;
    step();
    checks++;
    if (outs_a !== 15'd0) begin
      errors++;
      $display("FAIL reset_in_mem got %b want %b", outs_a, 15'd0);
    end
    RESET = 1'b0; BUSYWAIT = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (outs_a !== 15'd0) begin
        errors++;
        $display("FAIL no_wb_after_reset%0d got %b want %b", i, outs_a, 15'd0);
      end
    end
  endtask

  initial begin
    RESET = 1'b1; OPCODE = 8'd0; INSTR_VALID = 1'b0; BUSYWAIT = 1'b0;
    #1;
    test_reset();
    test_alu_seq();
    test_load_busy();
    test_store_fast();
    test_timeout();
    test_illegal();
    test_reset_mid_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Registered, parametrised successor to the CPU's combinational opcode decoder.
- Decodes the extended ISA: ALU ops, J/BEQ/BNE, MULT, and the LWD/LWI/SWD/SWI memory ops.
- Sequences memory ops through a stall FSM driven by the data-memory BUSYWAIT, with a timeout counter.
- Sits between instruction fetch/decode and the register file, ALU, PC logic and data memory.

Parameters:
- OPCODE_W, 8: opcode width; opcodes are zero-extended compares against the map below.
- ALUOP_W, 3: ALUOP output width; minimum 3.
- MEM_TIMEOUT, 255: max BUSYWAIT-high cycles before abort; range 1..2^16-1.
- CNT_W, 16: timeout counter width; must hold MEM_TIMEOUT.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- OPCODE  input  OPCODE_W  opcode of current instruction.
- INSTR_VALID  input  1  OPCODE is a valid new instruction this cycle.
- BUSYWAIT  input  1  data memory busy.
- IMM  output  1  immediate-select mux.
- SIGN  output  1  two's-complement-negate mux.
- WRITEENABLE  output  1  register file write.
- WRITESRC  output  1  0 = ALU result, 1 = memory read data.
- J  output  1  jump.
- BEQ  output  1  branch-if-zero.
- BNE  output  1  branch-if-not-zero.
- ALUOP  output  ALUOP_W  ALU select.
- MEMREAD  output  1  data memory read request.
- MEMWRITE  output  1  data memory write request.
- PC_STALL  output  1  hold PC and fetch.
- ILLEGAL  output  1  one-cycle pulse: undefined opcode.
- MEM_ERR  output  1  one-cycle pulse: memory timeout.

Behaviour:
- All outputs are registered. Decode of OPCODE sampled at edge N is visible after edge N; latency is 1 cycle.
- Reset (sync): every output = 0, state = RUN, counter = 0. RESET in any state, including MEM or WB, aborts the op; no MEMREAD/MEMWRITE/WRITEENABLE after that edge.
- Opcode map: IMM / SIGN / WE / ALUOP / other
  - 0 LOADI: 1/0/1/000
  - 1 MOV: 0/0/1/000
  - 2 ADD: 0/0/1/001
  - 3 SUB: 0/1/1/001
  - 4 AND: 0/0/1/010
  - 5 OR: 0/0/1/011
  - 6 J: WE = 0, J = 1
  - 7 BEQ: 0/1/0/001, BEQ = 1
  - 8 BNE: 0/1/0/001, BNE = 1
  - 9 MULT: 0/0/1/100
  - 10 LWD: 0/0/0/000, MEMREAD
  - 11 LWI: 1/0/0/000, MEMREAD
  - 12 SWD: 0/0/0/000, MEMWRITE
  - 13 SWI: 1/0/0/000, MEMWRITE
- Every unlisted signal is 0 for that opcode; no latches and no stale values.
- FSM states RUN, MEM, WB.
- RUN, INSTR_VALID = 0:
  - Bubble: all enables and branch signals 0; ALUOP = 0.
- RUN, INSTR_VALID = 1:
  - Non-memory opcode: outputs per map; stay in RUN.
  - Memory opcode: outputs per map, MEMREAD or MEMWRITE = 1, PC_STALL = 1; go to MEM; counter cleared.
  - Undefined opcode: all enables 0, ILLEGAL = 1 for exactly one cycle; stay in RUN.
- MEM:
  - IMM, ALUOP, MEMREAD and MEMWRITE held; PC_STALL = 1; INSTR_VALID and OPCODE ignored.
  - Counter increments each edge while BUSYWAIT = 1.
- MEM, BUSYWAIT sampled 0:
  - MEMREAD/MEMWRITE drop next cycle.
  - Load: go to WB.
  - Store: go to RUN with PC_STALL = 0.
- MEM, counter reaches MEM_TIMEOUT with BUSYWAIT still 1:
  - MEM_ERR pulses one cycle; MEMREAD/MEMWRITE drop; no WB; go to RUN with PC_STALL = 0.
- WB (one cycle, loads only): WRITEENABLE = 1, WRITESRC = 1, PC_STALL = 1; then RUN with PC_STALL = 0.
- BUSYWAIT already 0 on the first MEM cycle: minimum load = 3 cycles (RUN → MEM → WB); minimum store = 2 cycles.
- WRITESRC = 1 only in WB; 0 otherwise.

Test Plan:
- Reset: RESET = 1 for 2 cycles with OPCODE = 2, INSTR_VALID = 1 → all outputs 0. After release, ADD decodes: WE = 1, ALUOP = 001, SIGN = 0 one cycle after the edge.
- ALU sequence: LOADI, SUB, BEQ, BNE, J, MULT back-to-back →
  - LOADI: IMM = 1, WE = 1, ALUOP = 000.
  - SUB: SIGN = 1, ALUOP = 001.
  - BEQ: BEQ = 1, WE = 0.
  - BNE: BNE = 1.
  - J: J = 1, WE = 0.
  - MULT: ALUOP = 100.
  - No extra stall cycles.
- LWD with BUSYWAIT high for 4 cycles → MEMREAD = 1 and PC_STALL = 1 for 5 cycles, then WB: WE = 1, WRITESRC = 1 for 1 cycle, then PC_STALL = 0.
- SWI with BUSYWAIT = 0 throughout → MEMWRITE = 1, IMM = 1 for 1 cycle; no WE; PC_STALL = 0 after 2 cycles.
- MEM_TIMEOUT = 5, LWI, BUSYWAIT stuck 1 → MEM_ERR pulses once after 5 busy cycles; no WE; back in RUN.
- Opcode 0xFF → ILLEGAL = 1 for exactly 1 cycle, all enables 0. RESET asserted mid-MEM → MEMREAD = 0 next cycle, no WB.
